// File: rtl/ir_tx_if.sv
// Start/data request and frame outputs of the NEC IR transmitter.
// The master side drives the request and the slave side (ir_tx) drives status and line outputs.
interface ir_tx_if;
    logic        i_start;
    logic [31:0] i_data;
    logic        o_busy;
    logic        o_done;
    logic        o_ir_tx;
    logic        o_ir_txb;
    logic        o_ir_mod;

    modport master (
        output i_start, i_data,
        input  o_busy, o_done, o_ir_tx, o_ir_txb, o_ir_mod
    );

    modport slave (
        input  i_start, i_data,
        output o_busy, o_done, o_ir_tx, o_ir_txb, o_ir_mod
    );
endinterface

// File: rtl/ir_tx.sv
// NEC-format IR transmitter: lead mark/space, 32 pulse-distance bits sent MSB first,
// a stop mark and a guard space, with baseband, inverted and carrier-modulated outputs.
module ir_tx #(
    parameter int TICK_DIV      = 50,
    parameter int CARR_HALF     = 658,
    parameter int GAP_US        = 2000,
    parameter int LEAD_MARK_US  = 9000,
    parameter int LEAD_SPACE_US = 4500,
    parameter int BIT_MARK_US   = 560,
    parameter int ZERO_US       = 560,
    parameter int ONE_US        = 1690,
    parameter int STOP_US       = 560
) (
    input  logic    clk,
    input  logic    rst,
    ir_tx_if.slave  bus
);
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LEAD_MARK  = 3'd1;
    localparam logic [2:0] S_LEAD_SPACE = 3'd2;
    localparam logic [2:0] S_BIT_MARK   = 3'd3;
    localparam logic [2:0] S_BIT_SPACE  = 3'd4;
    localparam logic [2:0] S_STOP_MARK  = 3'd5;
    localparam logic [2:0] S_GAP        = 3'd6;

    localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int CW = (CARR_HALF > 1) ? $clog2(CARR_HALF) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CAR_LAST = CW'(CARR_HALF - 1);

    localparam logic [15:0] D_LM   = 16'(LEAD_MARK_US);
    localparam logic [15:0] D_LS   = 16'(LEAD_SPACE_US);
    localparam logic [15:0] D_BM   = 16'(BIT_MARK_US);
    localparam logic [15:0] D_ZERO = 16'(ZERO_US);
    localparam logic [15:0] D_ONE  = 16'(ONE_US);
    localparam logic [15:0] D_SM   = 16'(STOP_US);
    localparam logic [15:0] D_GAP  = 16'(GAP_US);

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] pre_q,   pre_d;
    logic [15:0]   dur_q,   dur_d;
    logic [5:0]    bit_q,   bit_d;
    logic [31:0]   sh_q,    sh_d;
    logic [CW-1:0] ccnt_q,  ccnt_d;
    logic          car_q,   car_d;

    logic tick, seg_end, mark_q, mark_d;

    function automatic logic is_mark(input logic [2:0] s);
        return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
    endfunction

    // Prescaler idles at 0, so a new frame's first tick lands exactly TICK_DIV cycles in.
    assign tick    = (state_q != S_IDLE) && (pre_q == PRE_LAST);
    assign seg_end = tick && (dur_q == 16'd1);
    assign mark_q  = is_mark(state_q);

    always_comb begin
        state_d = state_q;
        dur_d   = dur_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        pre_d   = '0;
        if (state_q != S_IDLE && !tick) pre_d = pre_q + PW'(1);
        if (tick) dur_d = dur_q - 16'd1;

        unique case (state_q)
            S_IDLE: if (bus.i_start) begin
                state_d = S_LEAD_MARK;
                dur_d   = D_LM;
                sh_d    = bus.i_data;
                bit_d   = '0;
            end
            S_LEAD_MARK: if (seg_end) begin
                state_d = S_LEAD_SPACE;
                dur_d   = D_LS;
            end
            S_LEAD_SPACE: if (seg_end) begin
                state_d = S_BIT_MARK;
                dur_d   = D_BM;
            end
            S_BIT_MARK: if (seg_end) begin
                state_d = S_BIT_SPACE;
                dur_d   = sh_q[31] ? D_ONE : D_ZERO;
            end
            S_BIT_SPACE: if (seg_end) begin
                sh_d  = {sh_q[30:0], 1'b0};
                bit_d = bit_q + 6'd1;
                if (bit_q == 6'd31) begin
                    state_d = S_STOP_MARK;
                    dur_d   = D_SM;
                end else begin
                    state_d = S_BIT_MARK;
                    dur_d   = D_BM;
                end
            end
            S_STOP_MARK: if (seg_end) begin
                state_d = S_GAP;
                dur_d   = D_GAP;
            end
            S_GAP: if (seg_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Carrier phase is cleared whenever the next cycle is a space, so every mark opens high.
    assign mark_d = is_mark(state_d);

    always_comb begin
        ccnt_d = '0;
        car_d  = 1'b0;
        if (mark_d && mark_q) begin
            if (ccnt_q == CAR_LAST) begin
                car_d = ~car_q;
            end else begin
                ccnt_d = ccnt_q + CW'(1);
                car_d  = car_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            dur_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            ccnt_q  <= '0;
            car_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            dur_q   <= dur_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            ccnt_q  <= ccnt_d;
            car_q   <= car_d;
        end
    end

    assign bus.o_busy   = (state_q != S_IDLE);
    assign bus.o_done   = (state_q == S_GAP) && seg_end;
    assign bus.o_ir_tx  = mark_q;
    assign bus.o_ir_txb = ~mark_q;
    assign bus.o_ir_mod = mark_q & ~car_q;
endmodule

// File: tb/tb_ir_tx.sv
// Bench for ir_tx with shortened segment durations; a line monitor decodes each frame
// from o_ir_txb and checks it against the queue of words expected to be sent.
module tb_ir_tx;
    localparam int T = 2, CH = 3, GAP = 4;
    localparam int LM = 16, LS = 8, BM = 2, ZS = 2, OS = 6, SM = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ir_tx_if bus();

    ir_tx #(
        .TICK_DIV(T), .CARR_HALF(CH), .GAP_US(GAP),
        .LEAD_MARK_US(LM), .LEAD_SPACE_US(LS), .BIT_MARK_US(BM),
        .ZERO_US(ZS), .ONE_US(OS), .STOP_US(SM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    function automatic int frame_cycles(input logic [31:0] w);
        int ones;
        ones = $countones(w);
        return (LM + LS + 32 * BM + (32 - ones) * ZS + ones * OS + SM + GAP) * T;
    endfunction

    function automatic int seg_len(input int seg, input logic [31:0] w);
        int idx;
        if (seg == 0) return LM * T;
        if (seg == 1) return LS * T;
        if (seg == 66) return SM * T;
        if (seg >= 2 && seg <= 65) begin
            if (seg % 2 == 0) return BM * T;
            idx = (seg - 3) / 2;
            return w[31 - idx] ? OS * T : ZS * T;
        end
        return -1;
    endfunction

    // Frame monitor / scoreboard consumer
    logic        mon_act = 1'b0, mon_cur = 1'b0, mon_orphan = 1'b0;
    logic        mon_prev_done = 1'b0, mon_bad = 1'b0;
    int          mon_run = 0, mon_seg = 0, mon_cyc = 0;
    logic [31:0] mon_word = '0, mon_exp = '0;

    always @(negedge clk) begin
        int   el;
        logic env;
        env = ~bus.o_ir_txb;
        if (bus.o_ir_txb !== ~bus.o_ir_tx || (bus.o_ir_tx === 1'b0 && bus.o_ir_mod !== 1'b0))
            mon_bad = 1'b1;
        if (mon_prev_done) begin
            n_cmp++;
            if (bus.o_busy !== 1'b0) begin
                n_err++;
                $display("FAIL busy_fall: o_busy=%b the cycle after o_done, want 0", bus.o_busy);
            end
        end
        mon_prev_done = 1'b0;
        if (bus.o_busy !== 1'b1) begin
            mon_act = 1'b0;
        end else begin
            if (!mon_act) begin
                mon_act = 1'b1; mon_seg = 0; mon_run = 0; mon_cyc = 0;
                mon_word = '0; mon_cur = env; mon_bad = 1'b0;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_frame: o_busy rose with no start pending, want idle");
                    mon_orphan = 1'b1; mon_exp = '0;
                end else begin
                    mon_orphan = 1'b0; mon_exp = exp_q[0];
                end
            end
            mon_cyc++;
            if (env === mon_cur) begin
                mon_run++;
            end else begin
                el = seg_len(mon_seg, mon_exp);
                if (mon_seg >= 3 && mon_seg <= 65 && mon_seg % 2 == 1)
                    mon_word = {mon_word[30:0], (mon_run > (ZS + OS) * T / 2)};
                n_cmp++;
                if (mon_run != el || mon_cur !== (mon_seg % 2 == 0)) begin
                    n_err++;
                    $display("FAIL seg%0d: level %b for %0d cycles, want level %b for %0d",
                             mon_seg, mon_cur, mon_run, (mon_seg % 2 == 0), el);
                end
                mon_seg++; mon_cur = env; mon_run = 1;
            end
            if (bus.o_done === 1'b1) begin
                n_cmp++;
                if (mon_seg != 67 || mon_cur !== 1'b0 || mon_run != GAP * T) begin
                    n_err++;
                    $display("FAIL gap: seg %0d level %b len %0d at done, want seg 67 level 0 len %0d",
                             mon_seg, mon_cur, mon_run, GAP * T);
                end
                n_cmp++;
                if (mon_word !== mon_exp) begin
                    n_err++;
                    $display("FAIL decoded_word: got %h, want %h", mon_word, mon_exp);
                end
                n_cmp++;
                if (mon_cyc != frame_cycles(mon_exp)) begin
                    n_err++;
                    $display("FAIL busy_len: o_busy high %0d cycles, want %0d", mon_cyc, frame_cycles(mon_exp));
                end
                n_cmp++;
                if (mon_bad !== 1'b0) begin
                    n_err++;
                    $display("FAIL line_outputs: txb/mod inconsistent with tx during frame, want txb=~tx and mod=0 in spaces");
                end
                if (!mon_orphan) void'(exp_q.pop_front());
                mon_prev_done = 1'b1;
                mon_act = 1'b0;
            end
        end
    end

    task automatic send(input logic [31:0] w);
        @(negedge clk);
        bus.i_data  = w;
        bus.i_start = 1'b1;
        exp_q.push_back(w);
        @(negedge clk);
        bus.i_start = 1'b0;
        n_cmp++;
        if (bus.o_busy !== 1'b1 || bus.o_ir_tx !== 1'b1 || bus.o_ir_mod !== 1'b1) begin
            n_err++;
            $display("FAIL start_edge: busy=%b tx=%b mod=%b one cycle after start, want 1 1 1",
                     bus.o_busy, bus.o_ir_tx, bus.o_ir_mod);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.o_busy !== 1'b0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= 4000) begin
            n_err++;
            $display("FAIL %s_timeout: still busy after %0d cycles, want idle", nm, n);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (bus.o_done !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) begin
            n_cmp++; n_err++;
            $display("FAIL %s_done_timeout: no o_done within %0d cycles, want a pulse", nm, n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_ir_tx !== 1'b0 ||
            bus.o_ir_txb !== 1'b1 || bus.o_ir_mod !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: busy=%b done=%b tx=%b txb=%b mod=%b, want 0 0 0 1 0",
                     bus.o_busy, bus.o_done, bus.o_ir_tx, bus.o_ir_txb, bus.o_ir_mod);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_patterns();
        send(32'h0000_0000); wait_idle("zeros");
        send(32'hFFFF_FFFF); wait_idle("ones");
        send(32'h20DF_10EF); wait_idle("loop1");
        send(32'hA55A_0FF0); wait_idle("loop2");
    endtask

    task automatic test_carrier();
        logic prev;
        int   tog, highs;
        prev = 1'b0; tog = 0; highs = 0;
        send(32'h1357_9BDF);
        for (int k = 0; k < LM * T; k++) begin
            if (bus.o_ir_mod !== prev) tog++;
            prev = bus.o_ir_mod;
            @(negedge clk);
        end
        for (int k = 0; k < LS * T; k++) begin
            if (bus.o_ir_mod !== 1'b0) highs++;
            @(negedge clk);
        end
        n_cmp++;
        if (tog != 1 + (LM * T - 1) / CH) begin
            n_err++;
            $display("FAIL carrier_toggles: %0d in lead mark, want %0d", tog, 1 + (LM * T - 1) / CH);
        end
        n_cmp++;
        if (highs != 0) begin
            n_err++;
            $display("FAIL carrier_space: mod high %0d cycles in lead space, want 0", highs);
        end
        wait_idle("carrier");
    endtask

    task automatic test_start_while_busy();
        int t_ls, t_b17;
        t_ls  = LM * T + (LS * T) / 2;
        t_b17 = (LM + LS) * T + 17 * (BM + ZS) * T + (BM * T) / 2;
        send(32'h0000_0000);
        repeat (t_ls) @(negedge clk);
        bus.i_data = 32'hDEAD_BEEF; bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (t_b17 - t_ls - 1) @(negedge clk);
        bus.i_data = 32'hFFFF_0000; bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        wait_done("ignore");
        bus.i_data = 32'h5555_AAAA; bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (bus.o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_in_done: o_busy=%b after start in done cycle, want 0", bus.o_busy);
        end
        wait_idle("ignore");

        send(32'h1234_5678);
        wait_done("after_done");
        @(negedge clk);
        bus.i_data = 32'h0F0F_1234; bus.i_start = 1'b1;
        exp_q.push_back(32'h0F0F_1234);
        @(negedge clk);
        bus.i_start = 1'b0;
        n_cmp++;
        if (bus.o_busy !== 1'b1 || bus.o_ir_tx !== 1'b1) begin
            n_err++;
            $display("FAIL start_after_done: busy=%b tx=%b, want 1 1", bus.o_busy, bus.o_ir_tx);
        end
        wait_idle("after_done");
    endtask

    task automatic test_reset_mid();
        send(32'h0000_0000);
        repeat ((LM + LS) * T + 10 * (BM + ZS) * T + 1) @(negedge clk);
        n_cmp++;
        if (bus.o_ir_tx !== 1'b1) begin
            n_err++;
            $display("FAIL bit10_mark: tx=%b inside bit 10 mark, want 1", bus.o_ir_tx);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.o_ir_tx !== 1'b0 || bus.o_ir_mod !== 1'b0 || bus.o_ir_txb !== 1'b1 ||
            bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_abort: tx=%b mod=%b txb=%b busy=%b done=%b, want 0 0 1 0 0",
                     bus.o_ir_tx, bus.o_ir_mod, bus.o_ir_txb, bus.o_busy, bus.o_done);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send(32'hC3A5_5A3C);
        wait_idle("after_reset");
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_data  = '0;
        test_reset();
        test_patterns();
        test_carrier();
        test_start_while_busy();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ir_tx.md
# ir_tx

NEC-format infrared transmitter: accepts a 32-bit custom/data word with a start pulse and emits the complete frame (9 ms lead mark, 4.5 ms lead space, 32 pulse-distance bits, 560 µs stop mark, trailing guard space) as a baseband envelope, an inverted envelope and a 38 kHz carrier-modulated drive. It is the transmit end of the existing IR receive path. `o_ir_txb` connects directly to the receiver's active-low `i_ir_rxb` for loopback, and `o_ir_mod` drives the IR LED.

## Interface
- `TICK_DIV`, 50: clk cycles per 1 µs time base (50 MHz clk).
- `CARR_HALF`, 658: clk cycles per carrier half-period (50 MHz / 1316 ≈ 38 kHz).
- `GAP_US`, 2000: trailing space in µs after the stop mark before the frame is reported done. Range 1..65535.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_start`  in  1  one-cycle request to send `i_data`.
- `i_data`  in  32  frame word. Bit 31 is sent first.
- `o_busy`  out  1  high from the cycle after an accepted start until the done cycle, inclusive.
- `o_done`  out  1  one-cycle pulse at end of guard space.
- `o_ir_tx`  out  1  envelope: 1 = mark (carrier on), 0 = space.
- `o_ir_txb`  out  1  `~o_ir_tx`.
- `o_ir_mod`  out  1  `o_ir_tx` AND 38 kHz carrier.

## Operation
- State machine with 7 states:
  - IDLE
  - LEAD_MARK (9000 µs)
  - LEAD_SPACE (4500 µs)
  - BIT_MARK (560 µs)
  - BIT_SPACE (560 µs if bit = 0, 1690 µs if bit = 1)
  - STOP_MARK (560 µs)
  - GAP (GAP_US)
- Transitions:
  - IDLE → LEAD_MARK on `i_start`.
  - LEAD_MARK → LEAD_SPACE → BIT_MARK.
  - BIT_MARK → BIT_SPACE.
  - BIT_SPACE → BIT_MARK while bits remain. After the 32nd bit space → STOP_MARK.
  - STOP_MARK → GAP → IDLE.
- Accepted start: `i_data` is latched into a 32-bit shift register. The current bit is `shreg[31]`. Shift left by one at the end of each BIT_SPACE.
- Bit counter: 6 bits, 0..32. It increments at each BIT_SPACE exit; leaving BIT_SPACE with count = 31 goes to STOP_MARK.
- Time base:
  - A prescaler counts 0..TICK_DIV-1 and emits a 1-cycle µs tick when it wraps.
  - The prescaler is cleared when a start is accepted, so every segment lasts exactly duration × TICK_DIV clk cycles.
- Duration counter: 16-bit µs count. It is loaded per state, decrements on tick, and the state advances on the tick where it reaches 1.
- Envelope: `o_ir_tx` = 1 in LEAD_MARK, BIT_MARK and STOP_MARK; 0 otherwise. It is registered and derived from the state register, with no combinational path from `i_start`.
- Carrier:
  - Counter 0..CARR_HALF-1 toggles a carrier flop.
  - Counter and flop are held at 0 while `o_ir_tx` = 0, so each mark starts with carrier high.
  - `o_ir_mod` = 0 whenever `o_ir_tx` = 0.
- `i_start` while `o_busy` = 1 (including the `o_done` cycle) is ignored. The latched data does not change.
- `i_start` in the cycle after `o_done` is accepted.
- Reset values: state IDLE, `o_busy` 0, `o_done` 0, `o_ir_tx` 0, `o_ir_txb` 1, `o_ir_mod` 0, all counters and the shift register 0.
- Reset asserted mid-frame aborts immediately to those values; no done pulse is issued.

## Timing
- Start accepted at edge E0.
- Edge E0+1: `o_busy` = 1 and `o_ir_tx` = 1 (LEAD_MARK begins).
- Segment lengths in clk cycles: lead mark 450000, lead space 225000, bit mark 28000, 0-space 28000, 1-space 84500, stop 28000, gap GAP_US × 50.
- Frame mark/space portion = 13500 + 32 × 560 + N0 × 560 + N1 × 1690 + 560 µs, where N0 and N1 are the number of 0 and 1 bits.
- `o_done` is high in the final GAP cycle. `o_busy` falls the cycle after that.
- `o_ir_mod` first rising edge coincides with the `o_ir_tx` rising edge. It toggles every 658 cycles during a mark, and the carrier period is 1316 cycles.

## Test plan
- **All zeros:** reset, then `i_data` = 0x00000000 with a start pulse → `o_ir_tx` high for 450000 cycles, low 225000, then 32 × (high 28000 / low 28000), then high 28000. `o_done` arrives 49900 µs + 2000 µs after the start. `o_busy` is high exactly throughout.
- **All ones:** `i_data` = 0xFFFFFFFF → every bit space is 84500 cycles. The mark/space portion totals 86060 µs.
- **Loopback:** `o_ir_txb` → receiver `i_ir_rxb`, sending 0x20DF10EF and then 0xA55A0FF0 → the receiver's `o_data` equals each sent word after its frame.
- **Start while busy:** pulse `i_start` with different data in mid-LEAD_SPACE, in mid-bit 17, and in the `o_done` cycle → the frame is unchanged and no extra frame follows. A start one cycle after `o_done` → a new frame begins.
- **Reset mid-frame:** assert `rst` during bit 10's mark → same cycle: `o_ir_tx` 0, `o_ir_mod` 0, `o_ir_txb` 1, `o_busy` 0, no `o_done`. After release plus a start, a full frame is correct.
- **Carrier:** during the lead mark, count `o_ir_mod` edges → 684 toggles in 450000 cycles (period 1316). `o_ir_mod` stays at 0 through the whole lead space.
